// File: rtl/i2s_sample_fifo.sv
// I2S receive path: serial-to-word deserialiser with channel tagging, feeding a
// sample FIFO drained by an asynchronous RPi read strobe, with watermark IRQ and sticky flags.
module i2s_sample_fifo #(
    parameter int SAMPLE_W  = 24,
    parameter int ADDR_W    = 6,
    parameter int WATERMARK = 32,
    parameter int CH_W      = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial,
    input  logic                enable,
    input  logic [CH_W-1:0]     ws,
    input  logic                ready,
    input  logic                flag_clr,
    output logic [SAMPLE_W-1:0] data,
    output logic [CH_W-1:0]     data_ch,
    output logic                data_valid,
    output logic [ADDR_W:0]     level,
    output logic                rpi_interrupt,
    output logic                overflow,
    output logic                frame_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ENT_W = SAMPLE_W + CH_W;
    localparam int CNT_W = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_W - 1);
    localparam logic [ADDR_W:0]  WM   = (ADDR_W + 1)'(WATERMARK);
    localparam logic [ADDR_W:0]  FULL = (ADDR_W + 1)'(DEPTH);

    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_eff;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d, base, word_nx;
    logic [CH_W-1:0]     tag_q, tag_d, tag_eff;
    logic                resync, push;

    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [ADDR_W:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, lvl_d;
    logic                empty, full, pop_req, do_pop, do_push;
    logic                rdy_s1_q, rdy_s2_q, rdy_d3_q;
    logic                irq_d, ovf_d, ferr_d;

    // Deserialiser: a ws change mid-word restarts assembly with the offending bit as bit 0
    always_comb begin
        resync  = enable && (cnt_q != '0) && (ws != tag_q);
        cnt_eff = resync ? '0 : cnt_q;
        base    = resync ? '0 : shreg_q;
        tag_eff = (resync || cnt_q == '0) ? ws : tag_q;
        word_nx = base;
        if (MSB_FIRST != 0) begin
            word_nx = {base[SAMPLE_W-2:0], serial};
        end else begin
            word_nx[cnt_eff] = serial;
        end
        push    = enable && (cnt_eff == LAST);
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tag_d   = tag_q;
        if (enable) begin
            cnt_d   = push ? '0 : cnt_eff + 1'b1;
            shreg_d = word_nx;
            tag_d   = tag_eff;
        end
    end

    // FIFO control: a pop on empty never bypasses a same-cycle push
    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (level == '0);
        full     = (level == FULL);
        pop_req  = rdy_s2_q & ~rdy_d3_q;
        do_pop   = pop_req & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(do_push);
        rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(do_pop);
        lvl_d    = wr_ptr_d - rd_ptr_d;
        irq_d    = rpi_interrupt;
        if (lvl_d >= WM) begin
            irq_d = 1'b1;
        end else if (lvl_d == '0) begin
            irq_d = 1'b0;
        end
        ovf_d  = (overflow & ~flag_clr) | (push & full & ~do_pop);
        ferr_d = (frame_err & ~flag_clr) | resync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            shreg_q       <= '0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rdy_s1_q      <= 1'b1;
            rdy_s2_q      <= 1'b1;
            rdy_d3_q      <= 1'b1;
            data          <= '0;
            data_ch       <= '0;
            data_valid    <= 1'b0;
            rpi_interrupt <= 1'b0;
            overflow      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rdy_s1_q      <= ready;
            rdy_s2_q      <= rdy_s1_q;
            rdy_d3_q      <= rdy_s2_q;
            rpi_interrupt <= irq_d;
            overflow      <= ovf_d;
            frame_err     <= ferr_d;
            if (pop_req) begin
                data_valid <= ~empty;
                if (!empty) begin
                    {data_ch, data} <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                end
            end
        end
    end

    // Storage array carries no reset; occupancy is tracked purely by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {tag_eff, word_nx};
        end
    end
endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed bench for i2s_sample_fifo: expected pops go into a scoreboard queue and a
// monitor compares them three clocks after each ready rise; status outputs are checked inline.
module tb_i2s_sample_fifo;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rst, serial, enable, ready, flag_clr;
    logic [0:0]    ws;
    logic [SW-1:0] data;
    logic [0:0]    data_ch;
    logic          data_valid;
    logic [6:0]    level;
    logic          rpi_interrupt, overflow, frame_err;

    i2s_sample_fifo #(.SAMPLE_W(SW), .ADDR_W(6), .WATERMARK(32), .CH_W(1), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .serial(serial), .enable(enable), .ws(ws), .ready(ready),
        .flag_clr(flag_clr), .data(data), .data_ch(data_ch), .data_valid(data_valid),
        .level(level), .rpi_interrupt(rpi_interrupt), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [SW:0]   model[$];
    logic [SW+1:0] sb[$];
    logic [SW:0]   last_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop lands on the third clock edge that sees ready high
    initial begin
        logic prev;
        logic [SW+1:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            if (ready && !prev && !rst) begin
                repeat (2) @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 32'(data_valid), 32'hdead);
                end else begin
                    e = sb.pop_front();
                    chk("pop_valid", 32'(data_valid), 32'(e[SW+1]));
                    chk("pop_ch", 32'(data_ch), 32'(e[SW]));
                    chk("pop_data", 32'(data), 32'(e[SW-1:0]));
                end
            end
            prev = ready;
        end
    end

    task automatic send_bit(input logic b, input logic c);
        @(negedge clk);
        serial = b;
        ws = c;
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic model_push(input logic [SW-1:0] w, input logic c);
        if (model.size() < 64) model.push_back({c, w});
    endtask

    task automatic send_word(input logic [SW-1:0] w, input logic c);
        for (int i = SW - 1; i >= 0; i--) send_bit(w[i], c);
        model_push(w, c);
    endtask

    task automatic issue_pop();
        if (model.size() > 0) begin
            last_exp = model.pop_front();
            sb.push_back({1'b1, last_exp});
        end else begin
            sb.push_back({1'b0, last_exp});
        end
    endtask

    task automatic pop();
        @(negedge clk);
        ready = 1'b1;
        issue_pop();
        repeat (4) @(negedge clk);
        ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] w;
        rst = 1'b1; serial = 1'b0; enable = 1'b0; ws = '0; ready = 1'b0; flag_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(level), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_irq", 32'(rpi_interrupt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single word
        send_word(24'hA5C3F0, 1'b1);
        @(negedge clk);
        chk("single_level1", 32'(level), 1);
        pop();
        chk("single_level0", 32'(level), 0);
        chk("single_data", 32'(data), 32'hA5C3F0);
        chk("single_ch", 32'(data_ch), 1);

        // watermark hysteresis
        for (int i = 0; i < 32; i++) begin
            send_word(24'h100000 + 24'(i), i[0]);
            @(negedge clk);
            if (i == 30) chk("wm_below", 32'(rpi_interrupt), 0);
        end
        chk("wm_rise", 32'(rpi_interrupt), 1);
        for (int i = 0; i < 31; i++) pop();
        chk("wm_hold_level", 32'(level), 1);
        chk("wm_hold", 32'(rpi_interrupt), 1);
        pop();
        chk("wm_fall", 32'(rpi_interrupt), 0);

        // resync: 10 bits ws=0 then a full word on ws=1
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        chk("resync_noerr", 32'(frame_err), 0);
        send_word(24'h123456, 1'b1);
        @(negedge clk);
        chk("resync_ferr", 32'(frame_err), 1);
        chk("resync_level", 32'(level), 1);
        pop();
        chk("resync_data", 32'(data), 32'h123456);

        // pop on empty holds data
        pop();
        chk("empty_valid", 32'(data_valid), 0);
        chk("empty_hold", 32'(data), 32'h123456);

        // overflow: 65 words, last is dropped
        for (int i = 0; i < 65; i++) send_word(24'(i), 1'b0);
        @(negedge clk);
        chk("ovf_level", 32'(level), 64);
        chk("ovf_flag", 32'(overflow), 1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_ferr", 32'(frame_err), 0);

        // simultaneous push and pop while full
        w = 24'hBEEF01;
        for (int i = SW - 1; i >= 1; i--) send_bit(w[i], 1'b0);
        @(negedge clk);
        ready = 1'b1;
        issue_pop();
        @(negedge clk);
        send_bit(w[0], 1'b0);
        model_push(w, 1'b0);
        @(negedge clk);
        chk("simul_level", 32'(level), 64);
        chk("simul_ovf", 32'(overflow), 0);
        chk("simul_data", 32'(data), 0);
        repeat (2) @(negedge clk);
        ready = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 64; i++) pop();
        chk("drain_last", 32'(data), 32'hBEEF01);
        chk("drain_level", 32'(level), 0);

        // reset mid-word with 5 words buffered
        for (int i = 0; i < 5; i++) send_word(24'h0F0F00 + 24'(i), 1'b1);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_level", 32'(level), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        last_exp = '0;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_ferr", 32'(frame_err), 0);
        send_word(24'h5A5A5A, 1'b0);
        @(negedge clk);
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_ferr", 32'(frame_err), 0);
        pop();
        chk("post_rst_data", 32'(data), 32'h5A5A5A);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_sample_fifo.md
# i2s_sample_fifo

Parametrised I2S receive path: deserialises a bit-qualified serial stream into SAMPLE_W-bit words, tags each word with its channel, and buffers them in a 2^ADDR_W-entry FIFO that the Raspberry Pi drains one word per `ready` pulse. It sits between the I2S bit-timing front end and the RPi readout bus. A watermark interrupt with hysteresis and sticky overflow/framing flags are included. All logic runs on one clock.

## Interface
- SAMPLE_W, 24: bits per sample word (2..32).
- ADDR_W, 6: FIFO depth is 2^ADDR_W entries.
- WATERMARK, 32: level at which `rpi_interrupt` asserts (1..2^ADDR_W).
- CH_W, 1: channel tag width (2^CH_W channels).
- MSB_FIRST, 1: 1 = first bit received is the word MSB; 0 = first bit is the LSB.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- serial  in  1  serial data bit, sampled when `enable`=1.
- enable  in  1  bit-valid qualifier, one bit per cycle high.
- ws  in  CH_W  channel/word-select, sampled with each bit.
- ready  in  1  asynchronous RPi read strobe; each rising edge pops one word.
- flag_clr  in  1  synchronous pulse; clears `overflow` and `frame_err`.
- data  out  SAMPLE_W  last popped sample.
- data_ch  out  CH_W  channel tag of `data`.
- data_valid  out  1  1 = last pop attempt returned a word; 0 = FIFO was empty.
- level  out  ADDR_W+1  current FIFO occupancy (0..2^ADDR_W).
- rpi_interrupt  out  1  watermark interrupt.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- frame_err  out  1  sticky: `ws` changed mid-word.

## Operation
- Reset: `data`, `data_ch`, `data_valid`, `level`, `rpi_interrupt`, `overflow` and `frame_err` are 0. Pointers and the bit counter are 0. The `ready` synchroniser and edge-history flops reset to 1, so a `ready` held high through reset produces no pop.
- Deserialiser: each cycle with `enable`=1 shifts in `serial`. With MSB_FIRST=1 the shift is left. With MSB_FIRST=0, bit n is written to position n.
  - The bit counter runs 0..SAMPLE_W-1.
  - The channel tag is captured from `ws` at count 0.
- Resync: if `enable`=1, count≠0 and `ws`≠captured tag, the partial word is discarded and `frame_err` is set. That bit becomes bit 0 of a new word tagged with the new `ws`.
- Word completion: the enable cycle at count SAMPLE_W-1 pushes {tag, word} and resets the count to 0.
- Push with FIFO full and no simultaneous pop: the word is dropped, `overflow` is set, and pointers are unchanged.
- Pop: a rising edge of the synchronised `ready` pops the head into `data`/`data_ch` and sets `data_valid`=1.
  - Pop with FIFO empty: `data`/`data_ch` hold and `data_valid`=0.
- Simultaneous push and pop:
  - Both happen and `level` is unchanged.
  - When full: the push is accepted and there is no overflow.
  - When empty: the pop sees empty (no bypass) and the push lands, giving `level`=1.
- Pointers are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1). `level` = wr_ptr − rd_ptr.
- Interrupt hysteresis: `rpi_interrupt` sets when next-level ≥ WATERMARK. It clears when next-level = 0. Otherwise it holds.
- `flag_clr` clears both sticky flags. A set event in the same cycle wins, so the flag stays 1.
- `enable`=0 stalls the deserialiser. The count and partial word are retained.

## Timing
- Push: the word is complete at edge k. `level` and `rpi_interrupt` update at edge k.
- Pop latency: `ready` is synchronised through 2 flops, followed by edge detection. The pop occurs on the 3rd rising `clk` edge after `ready` is first sampled high, and `data` updates at that edge.
- `ready` must stay high ≥3 `clk` cycles and low ≥3 cycles between pulses. Shorter pulses may be missed.
- `rst` mid-word or mid-operation flushes the FIFO, discards the partial word and clears all flags at the next edge.

## Test plan
- Single word, MSB_FIRST=1: 24 enable bits of 0xA5C3F0 with `ws`=1, then one `ready` pulse -> `level` goes 1 then 0; `data`=0xA5C3F0, `data_ch`=1, `data_valid`=1.
- Watermark: push 32 words -> `rpi_interrupt` rises on the 32nd push. Pop 31 -> it stays 1. Pop 1 more -> it falls when `level`=0.
- Overflow: push 65 words with no reads -> `level`=64, `overflow`=1, and 64 pops return words 0..63 in order. Then `flag_clr` -> `overflow`=0.
- Resync: 10 bits with `ws`=0, then `ws`=1 for 24 bits -> `frame_err`=1 and exactly one word with tag 1 containing the last 24 bits.
- Empty and boundary handshakes:
  - Pop on empty -> `data_valid`=0 with `data` held.
  - Push and pop in the same cycle at `level`=64 -> `level` stays 64 and `overflow` stays 0.
- Reset: `rst` asserted after 12 bits of a word with `level`=5 -> all outputs 0. The next 24 bits form a clean word.
